// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
// Imported by fetch_unit_if, fetch_fifo and fetch_unit.
package fetch_pkg;

    localparam int              XLEN      = 32;
    localparam logic [XLEN-1:0] PC_INC    = 32'd4;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Instructions are word aligned; the low two target bits carry no meaning.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Valid/ready instruction stream from fetch (master) to decode (slave).
interface fetch_unit_if;
    import fetch_pkg::*;

    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;

    modport master (output instr_valid, output instr, output instr_pc, input instr_ready);
    modport slave  (input instr_valid, input instr, input instr_pc, output instr_ready);

endinterface

// File: rtl/fetch_fifo.sv
// Small circular FIFO of {pc, instr} entries with flush; head is read straight
// from storage flops, so a write is only visible the cycle after it lands.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic             head_valid,
    output fetch_entry_t     head
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign head_valid = (count_q != '0);
    assign do_pop     = pop & head_valid;
    assign count      = count_q;
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch initiator: PC, single in-flight read, buffered stream.
// Optional FETCH_PERF_EN adds saturating pop and stall counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              ADDR_W   = 7,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = 32'h00000000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              memRead,
    output logic              memWrite,
    output logic [ADDR_W-1:0] address,
    output logic [XLEN-1:0]   mem_in,
    input  logic [XLEN-1:0]   mem_out,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    fetch_unit_if.master      dec
`ifdef FETCH_PERF_EN
    ,
    output logic [XLEN-1:0]   perf_fetched,
    output logic [XLEN-1:0]   perf_stall
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int CRD_W = CNT_W + 1;

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  pend_pc_q, pend_pc_d;
    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] fifo_count;
    logic [CRD_W-1:0] credits_used;
    logic             head_valid, pop, issue, push;
    fetch_entry_t     head, push_entry;

    // A slot is reserved for the in-flight word, so the FIFO can never overflow.
    // Gating with rst_n keeps the read strobe low while held in reset.
    assign pop          = head_valid & dec.instr_ready;
    assign credits_used = CRD_W'(fifo_count) + CRD_W'(inflight_q) - CRD_W'(pop);
    assign issue        = rst_n & ~redirect_valid & (credits_used < CRD_W'(DEPTH));
    assign push         = inflight_q & ~redirect_valid;
    assign push_entry   = '{pc: pend_pc_q, instr: mem_out};

    assign memRead  = issue;
    assign address  = pc_q[ADDR_W-1:0];
    assign memWrite = 1'b0;
    assign mem_in   = '0;

    assign dec.instr_valid = head_valid;
    assign dec.instr       = head.instr;
    assign dec.instr_pc    = head.pc;

    always_comb begin
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        inflight_d = 1'b0;
        if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
        end else if (issue) begin
            pc_d       = pc_q + PC_INC;
            pend_pc_d  = pc_q;
            inflight_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            pend_pc_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .count     (fifo_count),
        .head_valid(head_valid),
        .head      (head)
    );

`ifdef FETCH_PERF_EN
    logic [XLEN-1:0] fetched_q, fetched_d;
    logic [XLEN-1:0] stall_q, stall_d;

    function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] v, input logic en);
        return (en && (v != '1)) ? v + XLEN'(1) : v;
    endfunction

    always_comb begin
        fetched_d = sat_inc(fetched_q, pop);
        stall_d   = sat_inc(stall_q, head_valid & ~dec.instr_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= '0;
            stall_q   <= '0;
        end else begin
            fetched_q <= fetched_d;
            stall_q   <= stall_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit against a registered-read instruction memory model.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int              ADDR_W   = 7;
    localparam int              DEPTH    = 2;
    localparam logic [XLEN-1:0] RESET_PC = 32'h00000000;

    logic              clk            = 1'b0;
    logic              rst_n          = 1'b0;
    logic              memRead;
    logic              memWrite;
    logic [ADDR_W-1:0] address;
    logic [31:0]       mem_in;
    logic [31:0]       mem_out        = '0;
    logic              redirect_valid = 1'b0;
    logic [31:0]       redirect_pc    = '0;
`ifdef FETCH_PERF_EN
    logic [31:0]       perf_fetched;
    logic [31:0]       perf_stall;
`endif

    fetch_unit_if dec_if ();

    fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .memRead       (memRead),
        .memWrite      (memWrite),
        .address       (address),
        .mem_in        (mem_in),
        .mem_out       (mem_out),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .dec           (dec_if.master)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_stall    (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] rom [32];

    always @(posedge clk) begin
        if (memRead) mem_out <= rom[address[6:2]];
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expected FIFO contents plus the one outstanding read.
    fetch_entry_t exp_q [$];
    logic         m_pend = 1'b0;
    logic [31:0]  m_pend_pc = '0;
    logic [31:0]  m_pc = RESET_PC;
    logic [31:0]  m_fetched = '0;
    logic [31:0]  m_stall = '0;
    logic         m_pop, m_issue, m_valid;
    int           m_occ;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_pend    = 1'b0;
            m_pc      = RESET_PC;
            m_fetched = '0;
            m_stall   = '0;
        end else begin
            m_valid = (exp_q.size() > 0);
            m_pop   = m_valid && dec_if.instr_ready;
            m_occ   = exp_q.size() + int'(m_pend) - int'(m_pop);
            m_issue = !redirect_valid && (m_occ < DEPTH);
            check_eq("memRead", memRead, m_issue);
            if (m_issue) check_eq("address", address, m_pc[6:0]);
            check_eq("tied_off", {memWrite, mem_in}, '0);
            check_eq("instr_valid", dec_if.instr_valid, m_valid);
            if (m_valid) begin
                check_eq("instr", dec_if.instr, exp_q[0].instr);
                check_eq("instr_pc", dec_if.instr_pc, exp_q[0].pc);
            end
`ifdef FETCH_PERF_EN
            check_eq("perf_fetched", perf_fetched, m_fetched);
            check_eq("perf_stall", perf_stall, m_stall);
            if (m_pop && m_fetched != '1) m_fetched++;
            if (m_valid && !dec_if.instr_ready && m_stall != '1) m_stall++;
`endif
            if (redirect_valid) begin
                exp_q.delete();
                m_pend = 1'b0;
                m_pc   = {redirect_pc[31:2], 2'b00};
            end else begin
                if (m_pop) void'(exp_q.pop_front());
                if (m_pend) exp_q.push_back('{pc: m_pend_pc, instr: rom[m_pend_pc[6:2]]});
                m_pend = m_issue;
                if (m_issue) begin
                    m_pend_pc = m_pc;
                    m_pc      = m_pc + 32'd4;
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_pc    = pc;
        redirect_valid = 1'b1;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    // Returns at the negedge where the head carries pc; n counts negedges seen.
    task automatic wait_pc(input logic [31:0] pc, input int budget, output int n);
        logic found;
        found = 1'b0;
        n     = 0;
        while (!found && n < budget) begin
            @(negedge clk);
            n++;
            if (dec_if.instr_valid && dec_if.instr_pc == pc) found = 1'b1;
        end
        check_eq($sformatf("reach_pc_%h", pc), found, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_memRead"}, memRead, 1'b0);
        check_eq({tag, "_valid"}, dec_if.instr_valid, 1'b0);
        check_eq({tag, "_instr"}, dec_if.instr, '0);
        check_eq({tag, "_pc"}, dec_if.instr_pc, '0);
`ifdef FETCH_PERF_EN
        check_eq({tag, "_perf"}, {perf_fetched, perf_stall}, '0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          n;
        logic        found;
        logic [31:0] held;

        for (int i = 0; i < 32; i++) rom[i] = 32'hA5000000 | (i << 2);
        rom[0]  = 32'h00700813;
        rom[1]  = 32'h00002217;
        rom[7]  = 32'h02080863;
        rom[18] = 32'hFD5FF0EF;
        dec_if.instr_ready = 1'b1;

        #3;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Cold start: first word three cycles after release, then one per cycle.
        wait_pc(32'h0, 10, n);
        check_eq("first_latency", n, 3);
        check_eq("first_instr", dec_if.instr, 32'h00700813);
        @(negedge clk);
        check_eq("second_pc", dec_if.instr_pc, 32'h4);
        check_eq("second_instr", dec_if.instr, 32'h00002217);
        @(posedge clk);
        #1;
        cycles(3);

        dec_if.instr_ready = 1'b0;
        @(negedge clk);
        held = dec_if.instr;
        repeat (4) begin
            @(negedge clk);
            check_eq("stall_hold", dec_if.instr, held);
        end
        check_eq("full_no_read", memRead, 1'b0);
        @(posedge clk);
        #1 dec_if.instr_ready = 1'b1;
        cycles(8);

        // Redirect while the 0x0C read is outstanding and the head is being popped.
        do_redirect(32'h0);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (memRead && address == 7'h0C) found = 1'b1;
        end
        check_eq("saw_read_0c", found, 1'b1);
        @(posedge clk);
        #1;
        do_redirect(32'h1C);
        @(negedge clk);
        check_eq("flush_next", dec_if.instr_valid, 1'b0);
        wait_pc(32'h1C, 10, n);
        check_eq("redir_latency", n, 2);
        check_eq("redir_instr", dec_if.instr, 32'h02080863);
        @(posedge clk);
        #1;

        do_redirect(32'h4B);
        wait_pc(32'h48, 10, n);
        check_eq("unaligned_instr", dec_if.instr, 32'hFD5FF0EF);
        @(posedge clk);
        #1;

        redirect_pc    = 32'h10;
        redirect_valid = 1'b1;
        cycles(1);
        redirect_pc = 32'h20;
        cycles(1);
        redirect_valid = 1'b0;
        wait_pc(32'h20, 10, n);
        check_eq("last_redirect", n, 3);
        @(posedge clk);
        #1;

        // PC runs past the 128-byte memory; instr_pc keeps the full value.
        do_redirect(32'h78);
        wait_pc(32'h80, 12, n);
        check_eq("wrap_instr", dec_if.instr, 32'h00700813);
        @(posedge clk);
        #1;

        for (int i = 0; i < 300; i++) begin
            dec_if.instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                redirect_pc    = ($urandom_range(0, 3) == 0) ? $urandom() : $urandom_range(0, 255);
                redirect_valid = 1'b1;
            end else begin
                redirect_valid = 1'b0;
            end
            cycles(1);
        end
        redirect_valid     = 1'b0;
        dec_if.instr_ready = 1'b1;
        cycles(4);

        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_pc(RESET_PC, 10, n);
        check_eq("restart_latency", n, 3);
        check_eq("restart_instr", dec_if.instr, 32'h00700813);
        @(posedge clk);
        #1;
        cycles(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
